isa_io_initiator: RTL and testbench

- ISA bus I/O-cycle master: turns single-byte register read/write requests from a host-side valid/ready interface into correctly timed ISA I/O cycles.
- Drives address, AEN, IOR#/IOW# and write data, and samples read data. Honours the responder's ready line and reports a timeout if the responder stalls.
- Sits between the CPU-side bus logic or a test sequencer and I/O-mapped peripherals such as the CGA CRTC, mode, color-select and status registers at 3D4h-3DAh.

---
 rtl/isa_io_initiator.sv | 191 +++++++++++++++++++
 tb/tb_isa_io_initiator.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_io_initiator.sv
// ISA bus I/O-cycle master. Turns single-byte host read/write requests into
// ISA I/O cycles: address setup, command strobe with wait-state extension and
// timeout, then address/data hold before reporting completion.
module isa_io_initiator #(
    parameter int         SETUP_CYCLES = 2,
    parameter int         CMD_CYCLES   = 4,
    parameter int         HOLD_CYCLES  = 1,
    parameter int         WAIT_TIMEOUT = 255,
    parameter logic [7:0] FLOAT_DATA   = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_timeout,
    output logic        busy,
    output logic [15:0] bus_a,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d,
    input  logic [7:0]  bus_in,
    input  logic        bus_dir,
    input  logic        bus_rdy
);

    typedef enum logic [1:0] {IDLE, SETUP, CMD, HOLD} state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] CMD_LAST   = 4'(CMD_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  wait_cnt, wait_n;
    logic        write_q, write_n;
    logic [7:0]  rd_q, rd_n;
    logic        to_q, to_n;
    logic [15:0] bus_a_n;
    logic        bus_aen_n, bus_ior_n, bus_iow_n;
    logic [7:0]  bus_d_n;
    logic        resp_valid_n, resp_timeout_n;
    logic [7:0]  resp_rdata_n;
    logic        end_cycle, timed_out;

    // Idle handshake is purely a function of the registered state.
    assign req_ready  = (state == IDLE);
    assign busy       = ~req_ready;
    assign bus_memr_l = 1'b1;
    assign bus_memw_l = 1'b1;

    // Next-state and next-output logic for the whole bus cycle; every register
    // holds its value unless the current phase says otherwise.
    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        wait_n         = wait_cnt;
        write_n        = write_q;
        rd_n           = rd_q;
        to_n           = to_q;
        bus_a_n        = bus_a;
        bus_aen_n      = bus_aen;
        bus_ior_n      = bus_ior_l;
        bus_iow_n      = bus_iow_l;
        bus_d_n        = bus_d;
        resp_valid_n   = 1'b0;
        resp_rdata_n   = resp_rdata;
        resp_timeout_n = resp_timeout;
        end_cycle      = 1'b0;
        timed_out      = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    write_n   = req_write;
                    bus_a_n   = req_addr;
                    bus_aen_n = 1'b0;
                    bus_d_n   = req_write ? req_wdata : 8'h00;
                    cnt_n     = 4'd0;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n  = 4'd0;
                    wait_n = 8'd0;
                    if (write_q) begin
                        bus_iow_n = 1'b0;
                    end else begin
                        bus_ior_n = 1'b0;
                    end
                    state_n = CMD;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            CMD: begin
                if (cnt != CMD_LAST) begin
                    cnt_n = cnt + 4'd1;
                end else if (bus_rdy) begin
                    end_cycle = 1'b1;
                end else if ((WAIT_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT)) begin
                    end_cycle = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end

                if (end_cycle) begin
                    bus_ior_n = 1'b1;
                    bus_iow_n = 1'b1;
                    rd_n      = write_q ? 8'h00 : (bus_dir ? bus_in : FLOAT_DATA);
                    to_n      = timed_out;
                    cnt_n     = 4'd0;
                    if (HOLD_CYCLES == 0) begin
                        bus_aen_n      = 1'b1;
                        resp_valid_n   = 1'b1;
                        resp_rdata_n   = rd_n;
                        resp_timeout_n = to_n;
                        state_n        = IDLE;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt == HOLD_LAST) begin
                    bus_aen_n      = 1'b1;
                    resp_valid_n   = 1'b1;
                    resp_rdata_n   = rd_q;
                    resp_timeout_n = to_q;
                    cnt_n          = 4'd0;
                    state_n        = IDLE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: begin
                state_n   = IDLE;
                bus_aen_n = 1'b1;
                bus_ior_n = 1'b1;
                bus_iow_n = 1'b1;
            end
        endcase
    end

    // State, counters and all bus outputs are registered; reset abandons any
    // cycle in flight without reporting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            wait_cnt     <= 8'd0;
            write_q      <= 1'b0;
            rd_q         <= 8'h00;
            to_q         <= 1'b0;
            bus_a        <= 16'h0000;
            bus_aen      <= 1'b1;
            bus_ior_l    <= 1'b1;
            bus_iow_l    <= 1'b1;
            bus_d        <= 8'h00;
            resp_valid   <= 1'b0;
            resp_rdata   <= 8'h00;
            resp_timeout <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            wait_cnt     <= wait_n;
            write_q      <= write_n;
            rd_q         <= rd_n;
            to_q         <= to_n;
            bus_a        <= bus_a_n;
            bus_aen      <= bus_aen_n;
            bus_ior_l    <= bus_ior_n;
            bus_iow_l    <= bus_iow_n;
            bus_d        <= bus_d_n;
            resp_valid   <= resp_valid_n;
            resp_rdata   <= resp_rdata_n;
            resp_timeout <= resp_timeout_n;
        end
    end

endmodule

// File: tb/tb_isa_io_initiator.sv
// Self-checking bench for isa_io_initiator: fixed vectors, randomized cycles
// against a timing/data reference model, back-to-back requests and mid-cycle reset.
module tb_isa_io_initiator;

    localparam int         SETUP = 2;
    localparam int         CMD   = 4;
    localparam int         HOLD  = 1;
    localparam int         TMO   = 255;
    localparam logic [7:0] FLOAT = 8'hFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_timeout;
    logic        busy;
    logic [15:0] bus_a;
    logic        bus_aen;
    logic        bus_ior_l;
    logic        bus_iow_l;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic [7:0]  bus_d;
    logic [7:0]  bus_in;
    logic        bus_dir;
    logic        bus_rdy;

    int checks = 0;
    int errors = 0;

    isa_io_initiator #(
        .SETUP_CYCLES(SETUP),
        .CMD_CYCLES  (CMD),
        .HOLD_CYCLES (HOLD),
        .WAIT_TIMEOUT(TMO),
        .FLOAT_DATA  (FLOAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_timeout(resp_timeout),
        .busy        (busy),
        .bus_a       (bus_a),
        .bus_aen     (bus_aen),
        .bus_ior_l   (bus_ior_l),
        .bus_iow_l   (bus_iow_l),
        .bus_memr_l  (bus_memr_l),
        .bus_memw_l  (bus_memw_l),
        .bus_d       (bus_d),
        .bus_in      (bus_in),
        .bus_dir     (bus_dir),
        .bus_rdy     (bus_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        bit          dir;
        int          rdy_low;
        int          exp_len;
        logic [7:0]  exp_rdata;
        bit          exp_to;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input string tag, input bit wr, input logic [15:0] addr,
                                   input logic [7:0] wdata, input logic [7:0] din, input bit dir,
                                   input int rdy_low, input int exp_len,
                                   input logic [7:0] exp_rdata, input bit exp_to);
        vec_t v;
        v.tag = tag; v.wr = wr; v.addr = addr; v.wdata = wdata; v.din = din; v.dir = dir;
        v.rdy_low = rdy_low; v.exp_len = exp_len; v.exp_rdata = exp_rdata; v.exp_to = exp_to;
        return v;
    endfunction

    // Reference model: ready held low for the first rdy_low strobe cycles.
    // The strobe naturally lasts until ready is seen high, never less than the
    // minimum; extensions beyond the timeout budget end it with the flag set.
    function automatic void refModel(input bit wr, input bit dir, input logic [7:0] din, input int rdy_low,
                                     output int len, output logic [7:0] rdata, output bit to);
        int natural_len;
        natural_len = (rdy_low + 1 > CMD) ? rdy_low + 1 : CMD;
        if (TMO != 0 && natural_len - CMD > TMO) begin
            len = CMD + TMO;
            to  = 1'b1;
        end else begin
            len = natural_len;
            to  = 1'b0;
        end
        rdata = wr ? 8'h00 : (dir ? din : FLOAT);
    endfunction

    // Runs one complete request, acting as the responder, and checks the
    // observed bus timing, stability and response against the expectations.
    task automatic applyStimulus(input string tag, input bit wr, input logic [15:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] din, input bit dir,
                                 input int rdy_low, input int exp_len,
                                 input logic [7:0] exp_rdata, input bit exp_to);
        int         n, k, budget, strobe_cnt, setup_cnt, aen_cnt, a_bad, d_bad, wrong_strobe;
        bit         done;
        logic       own_l, other_l;
        logic [7:0] exp_d;
        exp_d = wr ? wdata : 8'h00;
        strobe_cnt = 0; setup_cnt = 0; aen_cnt = 0; a_bad = 0; d_bad = 0; wrong_strobe = 0; done = 0;

        @(negedge clk);
        budget = 0;
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checkOutput({tag, ".ready"}, req_ready, 1);

        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        bus_rdy   = (rdy_low > 0) ? 1'b0 : 1'b1;
        bus_dir   = 1'b0;
        bus_in    = ~din;
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);

        n = 1;
        while (n < 600) begin
            if (resp_valid) begin
                done = 1;
                break;
            end
            if (!bus_aen) begin
                aen_cnt++;
                if (bus_a !== addr) a_bad++;
                if (bus_d !== exp_d) d_bad++;
            end
            own_l   = wr ? bus_iow_l : bus_ior_l;
            other_l = wr ? bus_ior_l : bus_iow_l;
            if (!other_l) wrong_strobe++;
            if (!own_l) begin
                k       = strobe_cnt;
                bus_rdy = (k < rdy_low) ? 1'b0 : 1'b1;
                bus_dir = dir;
                bus_in  = 8'(din + k - (exp_len - 1));
                strobe_cnt++;
            end else begin
                if (strobe_cnt == 0) setup_cnt++;
                bus_rdy = (strobe_cnt == 0 && rdy_low > 0) ? 1'b0 : 1'b1;
                bus_dir = 1'($urandom);
                bus_in  = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end

        checkOutput({tag, ".latency"}, done ? n : 0, 1 + SETUP + exp_len + HOLD);
        checkOutput({tag, ".strobe_len"}, strobe_cnt, exp_len);
        checkOutput({tag, ".setup_len"}, setup_cnt, SETUP);
        checkOutput({tag, ".aen_low_len"}, aen_cnt, SETUP + exp_len + HOLD);
        checkOutput({tag, ".addr_bad"}, a_bad, 0);
        checkOutput({tag, ".data_bad"}, d_bad, 0);
        checkOutput({tag, ".wrong_strobe"}, wrong_strobe, 0);
        checkOutput({tag, ".rdata"}, resp_rdata, exp_rdata);
        checkOutput({tag, ".timeout"}, resp_timeout, exp_to);
        checkOutput({tag, ".aen_done"}, bus_aen, 1);
        bus_rdy = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".pulse_one"}, resp_valid, 0);
        checkOutput({tag, ".rdata_hold"}, resp_rdata, exp_rdata);
    endtask

    // Continuous bus-protocol watch: no strobe overlap, address/data steady
    // while a strobe is low, memory strobes parked, busy mirrors ready.
    logic        prev_low = 1'b0;
    logic [15:0] prev_a;
    logic [7:0]  prev_d;
    always @(negedge clk) begin
        if (!reset) begin
            checks += 3;
            if (!bus_ior_l && !bus_iow_l) begin
                errors++;
                $display("[TB] FAIL strobe_overlap: ior_l=%b iow_l=%b, required not both 0", bus_ior_l, bus_iow_l);
            end
            if (busy !== ~req_ready) begin
                errors++;
                $display("[TB] FAIL busy_vs_ready: busy=%b req_ready=%b, required complementary", busy, req_ready);
            end
            if (bus_memr_l !== 1'b1 || bus_memw_l !== 1'b1) begin
                errors++;
                $display("[TB] FAIL mem_strobes: memr_l=%b memw_l=%b, required 1 1", bus_memr_l, bus_memw_l);
            end
            if (prev_low && (!bus_ior_l || !bus_iow_l)) begin
                checks++;
                if (bus_a !== prev_a || bus_d !== prev_d) begin
                    errors++;
                    $display("[TB] FAIL bus_stable: a=%h d=%h, required a=%h d=%h", bus_a, bus_d, prev_a, prev_d);
                end
            end
        end
        prev_low = !reset && (!bus_ior_l || !bus_iow_l);
        prev_a   = bus_a;
        prev_d   = bus_d;
    end

    initial begin
        #(10 * 50000);
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n, gap, budget, a_bad, resp_seen, len;
        bit          seen, wr, dir, to;
        logic [7:0]  rdata, din, wdata;
        logic [15:0] addr;
        int          rdy_low;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        bus_in = 8'h0; bus_dir = 1'b0; bus_rdy = 1'b1;

        vecs[0] = mkVec("wr_3d8",       1, 16'h03D8, 8'h29, 8'h00, 0, 0,      4,   8'h00, 0);
        vecs[1] = mkVec("rd_3da",       0, 16'h03DA, 8'h00, 8'hF9, 1, 0,      4,   8'hF9, 0);
        vecs[2] = mkVec("rd_3b0_float", 0, 16'h03B0, 8'h00, 8'h12, 0, 0,      4,   8'hFF, 0);
        vecs[3] = mkVec("rd_3d5_wait",  0, 16'h03D5, 8'h00, 8'h5A, 1, 9,      10,  8'h5A, 0);
        vecs[4] = mkVec("rdy_in_min",   1, 16'h03D9, 8'h30, 8'h00, 0, 3,      4,   8'h00, 0);
        vecs[5] = mkVec("one_wait",     0, 16'h03D4, 8'h00, 8'h0C, 1, 4,      5,   8'h0C, 0);
        vecs[6] = mkVec("timeout_wr",   1, 16'h03D4, 8'h0E, 8'h00, 0, 100000, 259, 8'h00, 1);
        vecs[7] = mkVec("timeout_rd",   0, 16'h03DA, 8'h00, 8'h88, 1, 259,    259, 8'h88, 1);
        vecs[8] = mkVec("last_wait",    0, 16'h03D5, 8'h00, 8'h77, 1, 258,    259, 8'h77, 0);
        vecs[9] = mkVec("wr_dir_ign",   1, 16'h03D9, 8'hA5, 8'h33, 1, 0,      4,   8'h00, 0);

        repeat (3) @(negedge clk);
        checkOutput("rst.req_ready", req_ready, 1);
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.resp_valid", resp_valid, 0);
        checkOutput("rst.resp_rdata", resp_rdata, 0);
        checkOutput("rst.resp_timeout", resp_timeout, 0);
        checkOutput("rst.bus_a", bus_a, 0);
        checkOutput("rst.bus_aen", bus_aen, 1);
        checkOutput("rst.strobes", {bus_ior_l, bus_iow_l}, 2'b11);
        checkOutput("rst.bus_d", bus_d, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].tag, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].din,
                          vecs[i].dir, vecs[i].rdy_low, vecs[i].exp_len, vecs[i].exp_rdata, vecs[i].exp_to);
        end

        for (int i = 0; i < 24; i++) begin
            wr    = 1'($urandom);
            dir   = 1'($urandom);
            addr  = 16'($urandom);
            wdata = 8'($urandom);
            din   = 8'($urandom);
            rdy_low = ($urandom_range(0, 5) == 0) ? int'($urandom_range(250, 262)) : int'($urandom_range(0, 8));
            refModel(wr, dir, din, rdy_low, len, rdata, to);
            applyStimulus($sformatf("rand%0d", i), wr, addr, wdata, din, dir, rdy_low, len, rdata, to);
        end

        // Back-to-back writes with req_valid held high, then reset in the second strobe.
        @(negedge clk);
        bus_rdy = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h03D4; req_wdata = 8'h0A;
        checkOutput("b2b.ready0", req_ready, 1);
        @(negedge clk);
        req_addr = 16'h03D5; req_wdata = 8'h06;
        n = 1; seen = 0; gap = 0; a_bad = 0;
        while (n < 40) begin
            if (!bus_iow_l) seen = 1;
            else if (seen) gap++;
            if (resp_valid) break;
            if (!bus_aen && (bus_a !== 16'h03D4 || bus_d !== 8'h0A)) a_bad++;
            @(negedge clk);
            n++;
        end
        checkOutput("b2b.resp_cycle", n, 8);
        checkOutput("b2b.ready_in_resp", req_ready, 1);
        checkOutput("b2b.first_bus_bad", a_bad, 0);
        checkOutput("b2b.first_rdata", resp_rdata, 0);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("b2b.second_busy", busy, 1);
        checkOutput("b2b.second_addr", bus_a, 16'h03D5);
        checkOutput("b2b.second_data", bus_d, 8'h06);
        checkOutput("b2b.second_aen", bus_aen, 0);
        budget = 0;
        while (bus_iow_l && budget < 20) begin
            gap++;
            @(negedge clk);
            budget++;
        end
        checkOutput("b2b.gap_ge3", (gap >= 3), 1);
        checkOutput("b2b.strobe2_low", bus_iow_l, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst.iow_l", bus_iow_l, 1);
        checkOutput("midrst.aen", bus_aen, 1);
        checkOutput("midrst.req_ready", req_ready, 1);
        checkOutput("midrst.resp_valid", resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        resp_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        checkOutput("midrst.no_resp", resp_seen, 0);

        applyStimulus("post_rst", 0, 16'h03DA, 8'h00, 8'h41, 1, 0, 4, 8'h41, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
